// File: rtl/pc_ctrl_pkg.sv
// Shared constants for the fetch-stage PC sequencer: pcsrc encodings,
// FSM state encoding and the width of the flush down-counter.
package pc_ctrl_pkg;

   localparam int CNT_W = 3;

   localparam logic [1:0] PCSRC_SEQ     = 2'b00;
   localparam logic [1:0] PCSRC_BRANCH  = 2'b01;
   localparam logic [1:0] PCSRC_EPC     = 2'b10;
   localparam logic [1:0] PCSRC_HANDLER = 2'b11;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

endpackage

// File: rtl/pc_ctrl_perf.sv
// Saturating performance counters for the PC sequencer: stall cycles and
// redirect events. Only instantiated when PC_CTRL_PERF_EN is defined.
module pc_ctrl_perf (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_stall_evt,
   input  logic        i_redirect_evt,
   output logic [31:0] o_stall_cnt,
   output logic [31:0] o_redirect_cnt
);

   logic [31:0] stallCnt_q;
   logic [31:0] redirectCnt_q;

   // Count events, holding at all-ones instead of wrapping.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stallCnt_q    <= '0;
         redirectCnt_q <= '0;
      end else begin
         if (i_stall_evt && (stallCnt_q != '1))
            stallCnt_q <= stallCnt_q + 32'd1;
         if (i_redirect_evt && (redirectCnt_q != '1))
            redirectCnt_q <= redirectCnt_q + 32'd1;
      end
   end

   assign o_stall_cnt    = stallCnt_q;
   assign o_redirect_cnt = redirectCnt_q;

endmodule

// File: rtl/pc_ctrl.sv
// Fetch-stage PC sequencer: chooses pcsrc / pcWrite from stall, branch,
// exception and eret events, owns EPC and EXL, and raises the pipeline
// flush strobe for FLUSH_CYCLES cycles after every redirect.
// Optional feature macro: PC_CTRL_PERF_EN (adds stall/redirect counters).
module pc_ctrl
   import pc_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int PC_W         = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_stall,
   input  logic            i_branch_taken,
   input  logic            i_exception,
   input  logic [PC_W-1:0] i_exc_pc,
   input  logic            i_eret,
   output logic [1:0]      o_pcsrc,
   output logic            o_pcWrite,
   output logic [PC_W-1:0] o_epc,
   output logic            o_exl,
   output logic            o_flush,
   output logic            o_double_fault,
   output logic            o_eret_err
`ifdef PC_CTRL_PERF_EN
   ,
   output logic [31:0]     o_stall_cnt,
   output logic [31:0]     o_redirect_cnt
`endif
);

   localparam logic [CNT_W-1:0] RELOAD =
      CNT_W'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PC_W-1:0]   epc_q, epc_d;
   logic              exl_q, exl_d;

   logic [1:0]        pcsrc;
   logic              pcWrite;
   logic              flush;
   logic              doubleFault;
   logic              eretErr;
   logic              redirect;

   // Event priority decode; an exception wins even while draining a flush.
   always_comb begin
      pcsrc       = PCSRC_SEQ;
      pcWrite     = 1'b1;
      flush       = 1'b0;
      doubleFault = 1'b0;
      eretErr     = 1'b0;
      redirect    = 1'b0;
      epc_d       = epc_q;
      exl_d       = exl_q;
      if (i_exception) begin
         pcsrc    = PCSRC_HANDLER;
         redirect = 1'b1;
         if (!exl_q) begin
            epc_d = i_exc_pc;
            exl_d = 1'b1;
         end else begin
            doubleFault = 1'b1;
         end
      end else if (state_q == ST_FLUSH) begin
         flush = 1'b1;
      end else if (i_eret) begin
         if (exl_q) begin
            pcsrc    = PCSRC_EPC;
            redirect = 1'b1;
            exl_d    = 1'b0;
         end else begin
            eretErr = 1'b1;
            pcWrite = !i_stall;
         end
      end else if (i_branch_taken) begin
         pcsrc    = PCSRC_BRANCH;
         redirect = 1'b1;
      end else if (i_stall) begin
         pcWrite = 1'b0;
      end
      if (redirect)
         flush = 1'b1;
   end

   // Next state: a redirect (re)loads the drain counter, FLUSH counts it down.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      if (redirect) begin
         if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            count_d = RELOAD;
         end else begin
            state_d = ST_RUN;
            count_d = '0;
         end
      end else if (state_q == ST_FLUSH) begin
         if (count_q == '0)
            state_d = ST_RUN;
         else
            count_d = count_q - 1'b1;
      end
   end

   // State, drain counter, EPC and EXL registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_RUN;
         count_q <= '0;
         epc_q   <= '0;
         exl_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         epc_q   <= epc_d;
         exl_q   <= exl_d;
      end
   end

   // Combinational outputs are forced quiet while reset is held.
   assign o_pcsrc        = i_rst_n ? pcsrc : PCSRC_SEQ;
   assign o_pcWrite      = i_rst_n && pcWrite;
   assign o_flush        = i_rst_n && flush;
   assign o_double_fault = i_rst_n && doubleFault;
   assign o_eret_err     = i_rst_n && eretErr;
   assign o_epc          = epc_q;
   assign o_exl          = exl_q;

`ifdef PC_CTRL_PERF_EN
   pc_ctrl_perf uPerf (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_stall_evt    ((state_q == ST_RUN) && !o_pcWrite),
      .i_redirect_evt (redirect),
      .o_stall_cnt    (o_stall_cnt),
      .o_redirect_cnt (o_redirect_cnt)
   );
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: reset, stall/branch, exception, double fault,
// eret (valid and invalid), exception inside FLUSH, and reset during FLUSH.
module tb_pc_ctrl;

   logic        clk = 1'b0;
   logic        rstN;
   logic        stall, branchTaken, exception, eret;
   logic [31:0] excPc;
   logic [1:0]  pcsrc;
   logic        pcWrite, exl, flush, doubleFault, eretErr;
   logic [31:0] epc;
`ifdef PC_CTRL_PERF_EN
   logic [31:0] stallCnt, redirectCnt;
`endif

   int checks = 0;
   int errors = 0;

   pc_ctrl #(.FLUSH_CYCLES(2), .PC_W(32)) dut (
      .i_clk          (clk),
      .i_rst_n        (rstN),
      .i_stall        (stall),
      .i_branch_taken (branchTaken),
      .i_exception    (exception),
      .i_exc_pc       (excPc),
      .i_eret         (eret),
      .o_pcsrc        (pcsrc),
      .o_pcWrite      (pcWrite),
      .o_epc          (epc),
      .o_exl          (exl),
      .o_flush        (flush),
      .o_double_fault (doubleFault),
      .o_eret_err     (eretErr)
`ifdef PC_CTRL_PERF_EN
      ,
      .o_stall_cnt    (stallCnt),
      .o_redirect_cnt (redirectCnt)
`endif
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Move to just after the next rising edge, drive inputs, settle mid-cycle.
   task automatic applyStimulus(input logic s, input logic b, input logic e,
                                input logic [31:0] pc, input logic r);
      @(posedge clk);
      #1;
      stall       = s;
      branchTaken = b;
      exception   = e;
      excPc       = pc;
      eret        = r;
      #2;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Check the five combinational outputs of the current cycle together.
   task automatic checkComb(input string tag, input logic [1:0] expSrc,
                            input logic expWr, input logic expFl,
                            input logic expDf, input logic expEe);
      checkOutput({tag, ".pcsrc"},   32'(pcsrc),       32'(expSrc));
      checkOutput({tag, ".pcWrite"}, 32'(pcWrite),     32'(expWr));
      checkOutput({tag, ".flush"},   32'(flush),       32'(expFl));
      checkOutput({tag, ".dfault"},  32'(doubleFault), 32'(expDf));
      checkOutput({tag, ".eretErr"}, 32'(eretErr),     32'(expEe));
   endtask

   initial begin
      rstN = 1'b0; stall = 1'b0; branchTaken = 1'b0;
      exception = 1'b0; eret = 1'b0; excPc = '0;
      #2;
      checkComb("reset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("reset.epc", epc, 32'h0);
      checkOutput("reset.exl", 32'(exl), 32'h0);
      #6;
      rstN = 1'b1;

      // T1: idle after reset
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 0, 32'h0, 0);
         checkComb("t1.idle", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
         checkOutput("t1.epc", epc, 32'h0);
         checkOutput("t1.exl", 32'(exl), 32'h0);
      end

      // T2: two stall cycles, then branch beats stall
      applyStimulus(1, 0, 0, 32'h0, 0);
      checkComb("t2.stall0", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1, 0, 0, 32'h0, 0);
      checkComb("t2.stall1", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1, 1, 0, 32'h0, 0);
      checkComb("t2.branch", 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1, 0, 0, 32'h0, 0);
      checkComb("t2.flush", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef PC_CTRL_PERF_EN
      checkOutput("t2.stallCnt", stallCnt, 32'd2);
      checkOutput("t2.redirectCnt", redirectCnt, 32'd1);
`endif
      applyStimulus(0, 0, 0, 32'h0, 0);
      checkComb("t2.run", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

      // T3: first exception, FLUSH ignores a branch
      applyStimulus(0, 0, 1, 32'h40, 0);
      checkComb("t3.exc", 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("t3.exlBefore", 32'(exl), 32'h0);
      applyStimulus(0, 1, 0, 32'h0, 0);
      checkComb("t3.flushIgnBr", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("t3.epc", epc, 32'h40);
      checkOutput("t3.exl", 32'(exl), 32'h1);
      applyStimulus(0, 0, 0, 32'h0, 0);
      checkComb("t3.run", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

      // T4: double fault keeps EPC, then eret returns
      applyStimulus(0, 0, 1, 32'h80, 0);
      checkComb("t4.dfault", 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
      applyStimulus(0, 0, 0, 32'h0, 0);
      checkOutput("t4.epcKept", epc, 32'h40);
      checkOutput("t4.exlKept", 32'(exl), 32'h1);
      applyStimulus(0, 0, 0, 32'h0, 0);
      applyStimulus(0, 0, 0, 32'h0, 1);
      checkComb("t4.eret", 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(0, 0, 0, 32'h0, 0);
      checkOutput("t4.exlCleared", 32'(exl), 32'h0);
      applyStimulus(0, 0, 0, 32'h0, 0);

      // T5: invalid eret, then combined events, then exception inside FLUSH
      applyStimulus(0, 0, 0, 32'h0, 1);
      checkComb("t5.eretErr", 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus(1, 0, 0, 32'h0, 1);
      checkComb("t5.eretErrStall", 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(0, 1, 1, 32'h100, 1);
      checkComb("t5.allEvents", 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(0, 0, 1, 32'h200, 0);
      checkComb("t5.excInFlush", 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("t5.epc", epc, 32'h100);
      checkOutput("t5.exl", 32'(exl), 32'h1);
      applyStimulus(0, 0, 0, 32'h0, 0);
      checkComb("t5.reloadFlush", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("t5.epcKept", epc, 32'h100);
      applyStimulus(0, 0, 0, 32'h0, 0);
      checkComb("t5.run", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

      // T6: reset asserted in the middle of a FLUSH cycle
      applyStimulus(0, 1, 0, 32'h0, 0);
      checkComb("t6.branch", 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(0, 0, 0, 32'h0, 0);
      checkComb("t6.inFlush", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
      rstN = 1'b0;
      #1;
      checkComb("t6.asyncRst", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("t6.epcRst", epc, 32'h0);
      checkOutput("t6.exlRst", 32'(exl), 32'h0);
      #1;
      rstN = 1'b1;
      applyStimulus(0, 0, 0, 32'h0, 0);
      checkComb("t6.runAfter", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
